// File: rtl/seg7_scan.sv
// Four-digit common-anode 7-segment scanner with per-frame snapshot and finish blink.
// Optional leading-zero blanking: define SEG7_SCAN_LZ_BLANK_EN.
module seg7_scan #(
    parameter int unsigned SCAN_DIV     = 1,
    parameter int unsigned BLINK_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] data,
    input  logic        finish,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  dig
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    dig_q, dig_d;

    logic          tick;
    logic          frame_end;
    logic [3:0]    nib;
    logic          blank;

    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        frame_end = tick && (idx_q == 2'd3);

        presc_d = tick ? '0 : presc_q + PW'(1);
        idx_d   = tick ? idx_q + 2'd1 : idx_q;
        snap_d  = frame_end ? data : snap_q;

        // Dropping finish clears the blink state outright so the display is never held dark.
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (!finish) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (frame_end) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end

        nib = snap_q[{idx_q, 2'b00} +: 4];
`ifdef SEG7_SCAN_LZ_BLANK_EN
        blank = ((idx_q == 2'd3) && (snap_q[15:12] == 4'h0)) ||
                ((idx_q == 2'd2) && (snap_q[15:8]  == 8'h00)) ||
                ((idx_q == 2'd1) && (snap_q[15:4]  == 12'h000));
`else
        blank = 1'b0;
`endif

        if (blink_ph_q) begin
            seg_d = '1;
            dig_d = '1;
            dp_d  = 1'b1;
        end else begin
            seg_d = blank ? '1 : hex_to_seg(nib);
            dig_d = ~(4'b0001 << idx_q);
            dp_d  = (idx_q != 2'd2);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q     <= '0;
            idx_q       <= '0;
            snap_q      <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            seg_q       <= '1;
            dp_q        <= 1'b1;
            dig_q       <= '1;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            dig_q       <= dig_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign dig = dig_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: constant vector table, hand-written corner
// sequences, and random stimulus against a slot/frame-level reference model.
module tb_seg7_scan;

    localparam int unsigned SD = 1;
    localparam int unsigned BF = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] data = 16'h0000;
    logic        finish = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig;

    always #5 clk = ~clk;

    seg7_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset_n(reset_n), .data(data), .finish(finish),
        .seg(seg), .dp(dp), .dig(dig)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16];

    // Reference model: slot counter, frame counter and a dark flag.
    int          m_sub, m_slot, m_frames;
    bit          m_dark;
    logic [15:0] m_snap;
    logic [6:0]  e_seg;
    logic [3:0]  e_dig;
    logic        e_dp;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sub = 0; m_slot = 0; m_frames = 0; m_dark = 0; m_snap = 16'h0000;
        e_seg = 7'h7F; e_dig = 4'hF; e_dp = 1'b1;
    endtask

    task automatic model_edge();
        int idx, nib;
        bit blank;
        idx   = m_slot % 4;
        nib   = int'((m_snap >> (4 * idx)) & 16'h000F);
        blank = 1'b0;
`ifdef SEG7_SCAN_LZ_BLANK_EN
        blank = (idx > 0) && ((m_snap >> (4 * idx)) == 16'h0000);
`endif
        if (m_dark) begin
            e_seg = 7'h7F; e_dig = 4'hF; e_dp = 1'b1;
        end else begin
            e_seg = blank ? 7'h7F : seg_tab[nib];
            e_dig = 4'hF ^ 4'(1 << idx);
            e_dp  = (idx == 2) ? 1'b0 : 1'b1;
        end
        if (m_sub == SD - 1) begin
            m_sub = 0;
            if (idx == 3) begin
                m_snap = data;
                if (finish) begin
                    m_frames++;
                    if (m_frames == BF) begin
                        m_frames = 0;
                        m_dark = !m_dark;
                    end
                end
            end
            m_slot++;
        end else begin
            m_sub++;
        end
        if (!finish) begin
            m_frames = 0;
            m_dark = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_seg", 16'(seg), 16'(e_seg));
        chk("model_dig", 16'(dig), 16'(e_dig));
        chk("model_dp", 16'(dp), 16'(e_dp));
    endtask

    // Run up to and including the next frame-end edge.
    task automatic capture();
        int n = 0;
        while (!((m_slot % 4 == 3) && (m_sub == SD - 1)) && n < 64) begin
            step();
            n++;
        end
        if (n >= 64) chk("capture_timeout", 16'(n), 16'd0);
        step();
    endtask

    typedef struct {
        logic [15:0]     d;
        logic [3:0][6:0] s;
    } vec_t;

    vec_t       vecs [6];
    logic [3:0] dig_exp [4];

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        dig_exp = '{4'hE, 4'hD, 4'hB, 4'h7};
        vecs[0] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{16'hABCD, {7'h08, 7'h03, 7'h46, 7'h21}};
        vecs[2] = '{16'h5678, {7'h12, 7'h02, 7'h78, 7'h00}};
        vecs[3] = '{16'h9EF0, {7'h10, 7'h06, 7'h0E, 7'h40}};
`ifdef SEG7_SCAN_LZ_BLANK_EN
        vecs[4] = '{16'h0005, {7'h7F, 7'h7F, 7'h7F, 7'h12}};
        vecs[5] = '{16'h0070, {7'h7F, 7'h7F, 7'h78, 7'h40}};
`else
        vecs[4] = '{16'h0005, {7'h40, 7'h40, 7'h40, 7'h12}};
        vecs[5] = '{16'h0070, {7'h40, 7'h40, 7'h78, 7'h40}};
`endif
        model_reset();

        // Reset state, then the first frame shows zeros.
        #12;
        chk("rst_seg", 16'(seg), 16'h007F);
        chk("rst_dig", 16'(dig), 16'h000F);
        chk("rst_dp", 16'(dp), 16'h0001);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("first_seg", 16'(seg), 16'h0040);
            chk("first_dig", 16'(dig), 16'(dig_exp[i]));
            chk("first_dp", 16'(dp), (i == 2) ? 16'h0000 : 16'h0001);
        end

        for (int v = 0; v < 6; v++) begin
            data = vecs[v].d;
            capture();
            for (int i = 0; i < 4; i++) begin
                step();
                chk("tab_seg", 16'(seg), 16'(vecs[v].s[i]));
                chk("tab_dig", 16'(dig), 16'(dig_exp[i]));
            end
        end

        // Mid-frame data change must not tear the current frame.
        data = 16'h1234;
        capture();
        step();
        chk("snap_d0", 16'(seg), 16'h0019);
        data = 16'hABCD;
        step();
        chk("snap_d1", 16'(seg), 16'h0030);
        step();
        chk("snap_d2", 16'(seg), 16'h0024);
        step();
        chk("snap_d3", 16'(seg), 16'h0079);
        step(); chk("snap_n0", 16'(seg), 16'h0021);
        step(); chk("snap_n1", 16'(seg), 16'h0046);
        step(); chk("snap_n2", 16'(seg), 16'h0003);
        step(); chk("snap_n3", 16'(seg), 16'h0008);

        // Blink: BF frames visible then BF frames dark.
        finish = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            chk("blink_dark", 16'(dig == 4'hF), (i >= 8 && i < 16) ? 16'd1 : 16'd0);
        end
        step();
        step();
        chk("blink_in_dark", 16'(dig), 16'h000F);
        finish = 1'b0;
        step();
        step();
        chk("unblink_vis", 16'(dig != 4'hF), 16'd1);

        // Asynchronous reset between edges at digit 2.
        begin
            int n = 0;
            while ((m_slot % 4 != 2) && n < 16) begin
                step();
                n++;
            end
        end
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_seg", 16'(seg), 16'h007F);
        chk("arst_dig", 16'(dig), 16'h000F);
        chk("arst_dp", 16'(dp), 16'h0001);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("arst_restart_dig", 16'(dig), 16'h000E);
        chk("arst_restart_seg", 16'(seg), 16'h0040);

        // Random data and finish activity against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) data = 16'($urandom);
            if ($urandom_range(3) == 0) data = data & 16'h00FF;
            if ($urandom_range(24) == 0) finish = ~finish;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
